// File: rtl/logic_chk_pkg.sv
// Shared types, op-codes and the per-bit golden function for the logic-gate response checker.
package logic_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;

    function automatic logic ref_bit(input int op, input logic a, input logic b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            default: return a & b;
        endcase
    endfunction

endpackage

// File: rtl/logic_ref_model.sv
// Combinational golden model of a two-input bitwise gate; also usable as a stand-in gate under test.
module logic_ref_model
    import logic_chk_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int OP    = OP_AND
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    always_comb begin
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c[i] = ref_bit(OP, a[i], b[i]);
        end
    end

endmodule

// File: rtl/logic_resp_checker.sv
// Response checker: compares gate output against the golden model, counts passes/fails, latches first failure.
// Optional macro LOGIC_CHK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module logic_resp_checker
    import logic_chk_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int OP    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_a,
    input  logic [WIDTH-1:0] smp_b,
    input  logic [WIDTH-1:0] smp_c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_vld,
    output logic             mismatch,
    output logic             all_pass
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] sample_idx_q, sample_idx_d;
    logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             first_fail_vld_q, first_fail_vld_d;
    logic             mismatch_q, mismatch_d;

    logic [WIDTH-1:0] expected;
    logic             sample_bad;
    logic             run_clear;

    logic_ref_model #(
        .WIDTH (WIDTH),
        .OP    (OP)
    ) u_ref (
        .a (smp_a),
        .b (smp_b),
        .c (expected)
    );

    // Case-inequality so an X/Z on the observed output is treated as a failure.
    assign sample_bad = smp_valid && (smp_c !== expected);
    assign run_clear  = start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN: begin
`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
                if (stop || sample_bad) state_d = DONE;
`else
                if (stop) state_d = DONE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters saturate rather than wrap so a very long run never reports a false pass.
    always_comb begin
        pass_cnt_d       = pass_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        sample_idx_d     = sample_idx_q;
        first_fail_idx_d = first_fail_idx_q;
        first_fail_vld_d = first_fail_vld_q;
        mismatch_d       = 1'b0;
        if (run_clear) begin
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
            sample_idx_d     = '0;
            first_fail_idx_d = '0;
            first_fail_vld_d = 1'b0;
        end else if (state_q == RUN && smp_valid) begin
            if (sample_bad) begin
                mismatch_d = 1'b1;
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
                if (!first_fail_vld_q) begin
                    first_fail_idx_d = sample_idx_q;
                    first_fail_vld_d = 1'b1;
                end
            end else begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
            end
            if (sample_idx_q != CNT_MAX) sample_idx_d = sample_idx_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            sample_idx_q     <= '0;
            first_fail_idx_q <= '0;
            first_fail_vld_q <= 1'b0;
            mismatch_q       <= 1'b0;
        end else begin
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            sample_idx_q     <= sample_idx_d;
            first_fail_idx_q <= first_fail_idx_d;
            first_fail_vld_q <= first_fail_vld_d;
            mismatch_q       <= mismatch_d;
        end
    end

    always_comb begin
        busy           = (state_q == RUN);
        done           = (state_q == DONE);
        pass_cnt       = pass_cnt_q;
        fail_cnt       = fail_cnt_q;
        first_fail_idx = first_fail_idx_q;
        first_fail_vld = first_fail_vld_q;
        mismatch       = mismatch_q;
        all_pass       = (state_q == DONE) && (fail_cnt_q == '0) && (pass_cnt_q != '0);
    end

endmodule

// File: tb/tb_logic_resp_checker.sv
// Bench: four checkers (AND/OR/XOR/NAND) share stimulus; each is scored against a behavioural model.
module tb_logic_resp_checker;

    localparam int W    = 4;
    localparam int CW   = 4;
    localparam int N    = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, smp_valid;
    logic [W-1:0] smp_a, smp_b;
    logic [W-1:0] smp_c [N];

    logic          busy [N];
    logic          done [N];
    logic [CW-1:0] pass_cnt [N];
    logic [CW-1:0] fail_cnt [N];
    logic [CW-1:0] first_fail_idx [N];
    logic          first_fail_vld [N];
    logic          mismatch [N];
    logic          all_pass [N];

    int total = 0;
    int bad   = 0;

    // Behavioural model: run phase 0=idle 1=running 2=finished, plain int counters.
    int m_phase [N];
    int m_pass [N];
    int m_fail [N];
    int m_idx [N];
    int m_ffi [N];
    bit m_ffv [N];
    bit m_mm [N];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        logic_resp_checker #(
            .WIDTH (W),
            .CNT_W (CW),
            .OP    (k)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .stop           (stop),
            .smp_valid      (smp_valid),
            .smp_a          (smp_a),
            .smp_b          (smp_b),
            .smp_c          (smp_c[k]),
            .busy           (busy[k]),
            .done           (done[k]),
            .pass_cnt       (pass_cnt[k]),
            .fail_cnt       (fail_cnt[k]),
            .first_fail_idx (first_fail_idx[k]),
            .first_fail_vld (first_fail_vld[k]),
            .mismatch       (mismatch[k]),
            .all_pass       (all_pass[k])
        );
    end

    function automatic logic [W-1:0] golden(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int satInc(input int v);
        return (v + 1 > CMAX) ? CMAX : v + 1;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) begin
            m_phase[k] = 0; m_pass[k] = 0; m_fail[k] = 0;
            m_idx[k] = 0; m_ffi[k] = 0; m_ffv[k] = 0; m_mm[k] = 0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < N; k++) begin
            bit failed;
            failed = 0;
            m_mm[k] = 0;
            if (m_phase[k] != 1) begin
                if (start) begin
                    m_phase[k] = 1; m_pass[k] = 0; m_fail[k] = 0;
                    m_idx[k] = 0; m_ffi[k] = 0; m_ffv[k] = 0;
                end
            end else begin
                if (smp_valid) begin
                    if (smp_c[k] !== golden(k, smp_a, smp_b)) begin
                        failed = 1;
                        m_mm[k] = 1;
                        m_fail[k] = satInc(m_fail[k]);
                        if (!m_ffv[k]) begin
                            m_ffi[k] = m_idx[k];
                            m_ffv[k] = 1;
                        end
                    end else begin
                        m_pass[k] = satInc(m_pass[k]);
                    end
                    m_idx[k] = satInc(m_idx[k]);
                end
                if (stop) m_phase[k] = 2;
`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
                if (failed) m_phase[k] = 2;
`endif
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < N; k++) begin
            string p;
            p = $sformatf("op%0d", k);
            checkOutput({p, " busy"}, busy[k], m_phase[k] == 1);
            checkOutput({p, " done"}, done[k], m_phase[k] == 2);
            checkOutput({p, " pass_cnt"}, pass_cnt[k], m_pass[k]);
            checkOutput({p, " fail_cnt"}, fail_cnt[k], m_fail[k]);
            checkOutput({p, " first_fail_vld"}, first_fail_vld[k], m_ffv[k]);
            checkOutput({p, " first_fail_idx"}, first_fail_idx[k], m_ffi[k]);
            checkOutput({p, " mismatch"}, mismatch[k], m_mm[k]);
            checkOutput({p, " all_pass"}, all_pass[k],
                        (m_phase[k] == 2) && (m_fail[k] == 0) && (m_pass[k] != 0));
        end
    endtask

    // c0 drives the AND checker directly; the other checkers see a golden value with random corruption.
    task automatic applyStimulus(input bit s, input bit p, input bit v,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c0, input int err_pct);
        @(negedge clk);
        start = s; stop = p; smp_valid = v; smp_a = a; smp_b = b;
        smp_c[0] = c0;
        for (int k = 1; k < N; k++) begin
            smp_c[k] = golden(k, a, b);
            if ($urandom_range(0, 99) < err_pct) smp_c[k] = smp_c[k] ^ W'($urandom_range(1, (1 << W) - 1));
        end
        @(posedge clk);
        modelStep();
        #1 checkAll();
    endtask

    task automatic randStep(input bit s, input bit p, input bit v, input int err_pct);
        logic [W-1:0] a, b, c;
        a = W'($urandom);
        b = W'($urandom);
        c = golden(0, a, b);
        if ($urandom_range(0, 99) < err_pct) c = c ^ W'($urandom_range(1, (1 << W) - 1));
        applyStimulus(s, p, v, a, b, c, err_pct);
    endtask

    initial begin
        int mm_seen;
        rst_n = 1'b0;
        start = 0; stop = 0; smp_valid = 0; smp_a = '0; smp_b = '0;
        for (int k = 0; k < N; k++) smp_c[k] = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 checkAll();
        @(negedge clk);
        rst_n = 1'b1;

        // Clean AND run
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("t1 done", done[0], 1);
        checkOutput("t1 pass_cnt", pass_cnt[0], 3);
        checkOutput("t1 fail_cnt", fail_cnt[0], 0);
        checkOutput("t1 all_pass", all_pass[0], 1);
        checkOutput("t1 first_fail_vld", first_fail_vld[0], 0);

        // Two failures, first at index 1
        mm_seen = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 0); mm_seen += int'(mismatch[0]);
        applyStimulus(0, 0, 1, 1, 0, 1, 0); mm_seen += int'(mismatch[0]);
        applyStimulus(0, 0, 1, 0, 1, 1, 0); mm_seen += int'(mismatch[0]);
        applyStimulus(0, 1, 0, 0, 0, 0, 0); mm_seen += int'(mismatch[0]);
        checkOutput("t2 pass_cnt", pass_cnt[0], 1);
        checkOutput("t2 fail_cnt", fail_cnt[0], 2);
        checkOutput("t2 first_fail_idx", first_fail_idx[0], 1);
        checkOutput("t2 mismatch pulses", mm_seen, 2);
        checkOutput("t2 all_pass", all_pass[0], 0);

        // Empty run, then restart clears
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 cleared fail_cnt", fail_cnt[0], 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("t3 done", done[0], 1);
        checkOutput("t3 all_pass empty", all_pass[0], 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t3 busy", busy[0], 1);

        // start in RUN ignored; sample with stop counted
        applyStimulus(0, 0, 1, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4 start in run pass_cnt", pass_cnt[0], 1);
        applyStimulus(0, 1, 1, 1, 1, 0, 0);
        checkOutput("t4 stop sample fail_cnt", fail_cnt[0], 1);
        checkOutput("t4 done", done[0], 1);

        // start+stop together: start wins outside RUN, stop wins in RUN
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("t4 start+stop idle busy", busy[0], 1);
        applyStimulus(1, 1, 1, 1, 1, 1, 0);
        checkOutput("t4 start+stop run done", done[0], 1);
        checkOutput("t4 start+stop run pass", pass_cnt[0], 1);

        // Asynchronous reset mid-run
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 1, 1, 1, 1, 0);
        checkOutput("t5 pass before reset", pass_cnt[0], 5);
        @(negedge clk);
        start = 0; stop = 0; smp_valid = 0;
        #1 rst_n = 1'b0;
        #1 modelReset();
        checkOutput("t5 busy in reset", busy[0], 0);
        checkOutput("t5 pass in reset", pass_cnt[0], 0);
        checkAll();
        #1 rst_n = 1'b1;
        applyStimulus(0, 0, 1, 1, 1, 1, 0);
        checkOutput("t5 idle after release", busy[0], 0);

        // Saturation: first failure after saturation records the saturated index
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        repeat (CMAX + 3) applyStimulus(0, 0, 1, 1, 1, 1, 0);
        checkOutput("sat pass_cnt", pass_cnt[0], CMAX);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        checkOutput("sat first_fail_idx", first_fail_idx[0], CMAX);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        checkOutput("sof done", done[0], 1);
        applyStimulus(0, 0, 1, 1, 1, 1, 0);
        checkOutput("sof pass_cnt", pass_cnt[0], 1);
        checkOutput("sof fail_cnt", fail_cnt[0], 1);
        checkOutput("sof first_fail_idx", first_fail_idx[0], 1);
`endif

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            int len;
            int err;
            len = $urandom_range(0, 22);
            err = (r % 4 == 0) ? 0 : 20;
            randStep(1, $urandom_range(0, 9) == 0, $urandom_range(0, 1), err);
            for (int i = 0; i < len; i++) begin
                randStep($urandom_range(0, 19) == 0, 0, $urandom_range(0, 9) < 7, err);
            end
            randStep($urandom_range(0, 1), 1, $urandom_range(0, 1), err);
            randStep(0, 0, $urandom_range(0, 1), err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
